// File: rtl/vector_normalize_iter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vector_norm_pkg
//  Description : Shared types and width helpers for the iterative vector
//                normaliser. Holds the controller state encoding and the
//                exact widths of the sum-of-squares, squared target and
//                search comparison products.
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef FIXED_W
`define FIXED_W 32
`endif
`ifndef FIXED_FRACTION_W
`define FIXED_FRACTION_W 16
`endif

package vector_norm_pkg;

  // Datapath-wide fixed-point format defaults.
  localparam int C_FIXED_W          = `FIXED_W;
  localparam int C_FIXED_FRACTION_W = `FIXED_FRACTION_W;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SUMSQ  = 3'd1,
    SEARCH = 3'd2,
    SCALE  = 3'd3,
    DONE   = 3'd4
  } norm_state_t;

  // Exact width of sum(c_i^2): each square needs 2*w bits, the DIM-way sum
  // needs clog2(DIM) carry bits on top.
  function automatic int q_width(input int w, input int d);
    return 2 * w + $clog2(d);
  endfunction

  // Exact width of target^2.
  function automatic int t_width(input int w);
    return 2 * w;
  endfunction

  // Exact width of trial^2 * Q, which also covers T << (2*FRAC) when
  // FRAC <= WIDTH.
  function automatic int prod_width(input int w, input int d);
    return 4 * w + $clog2(d);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vector_normalize_iter_if.sv
`default_nettype none
// ============================================================================
//  Module      : vector_normalize_iter_if
//  Description : Operand/result handshake bundle for vector_normalize_iter.
//                master = producer/consumer side, slave = normaliser side.
//  Signals     : in_valid/in_ready   operand handshake
//                in_vec              DIM packed signed components (comp 0 LSBs)
//                in_target           unsigned target length, FRAC fraction bits
//                out_valid/out_ready result handshake
//                out_vec             DIM packed signed scaled components
//                out_scale           unsigned scale factor found
//                out_zero            input vector was all-zero
//                out_clamped         scale saturated at all-ones
//  Revision    : 1.0 - initial release
// ============================================================================
interface vector_normalize_iter_if
  import vector_norm_pkg::*;
#(
  parameter int WIDTH = C_FIXED_W,
  parameter int DIM   = 3
);

  logic                   in_valid;
  logic                   in_ready;
  logic [DIM*WIDTH-1:0]   in_vec;
  logic [WIDTH-1:0]       in_target;
  logic                   out_valid;
  logic                   out_ready;
  logic [DIM*WIDTH-1:0]   out_vec;
  logic [WIDTH-1:0]       out_scale;
  logic                   out_zero;
  logic                   out_clamped;

  modport master (
    output in_valid, in_vec, in_target, out_ready,
    input  in_ready, out_valid, out_vec, out_scale, out_zero, out_clamped
  );

  modport slave (
    input  in_valid, in_vec, in_target, out_ready,
    output in_ready, out_valid, out_vec, out_scale, out_zero, out_clamped
  );

endinterface

`default_nettype wire

// File: rtl/vector_normalize_iter_sum_squares.sv
`default_nettype none
// ============================================================================
//  Module      : vector_sum_squares
//  Description : Combinational, exact sum of squares of DIM signed components.
//                No truncation: the result carries 2*WIDTH+clog2(DIM) bits.
//  Ports       : i_vec    DIM*WIDTH packed signed components, comp 0 in LSBs
//                o_sumsq  unsigned exact sum of squares
//  Revision    : 1.0 - initial release
// ============================================================================
module vector_sum_squares
  import vector_norm_pkg::*;
#(
  parameter int WIDTH = C_FIXED_W,
  parameter int DIM   = 3
) (
  input  wire  [DIM*WIDTH-1:0]             i_vec,
  output logic [q_width(WIDTH, DIM)-1:0]   o_sumsq
);

  localparam int QW = q_width(WIDTH, DIM);

  logic [2*WIDTH-1:0] w_sq [DIM];

  for (genvar i = 0; i < DIM; i++) begin : g_sq
    logic        [WIDTH-1:0]   w_c;
    logic signed [2*WIDTH-1:0] w_c_ext;
    assign w_c     = i_vec[i*WIDTH +: WIDTH];
    assign w_c_ext = {{WIDTH{w_c[WIDTH-1]}}, w_c};
    // The true square is at most 2^(2*WIDTH-2), so the low 2*WIDTH bits of
    // the product are the exact non-negative value.
    assign w_sq[i] = w_c_ext * w_c_ext;
  end

  always_comb begin
    o_sumsq = '0;
    for (int i = 0; i < DIM; i++) begin
      o_sumsq = o_sumsq + QW'(w_sq[i]);
    end
  end

endmodule

`default_nettype wire

// File: rtl/vector_normalize_iter.sv
`default_nettype none
// ============================================================================
//  Module      : vector_normalize_iter
//  Description : Iterative handshaked vector normaliser. Finds the largest
//                unsigned scale s (FRAC fraction bits) with
//                s^2 * |v|^2 <= target^2 by an exact one-bit-per-cycle binary
//                search, then outputs v*s with floor and signed saturation.
//                Fixed latency: out_valid rises WIDTH+2 edges after accept.
//  Ports       : clk  rising-edge clock
//                rst  asynchronous active-high reset
//                bus  vector_normalize_iter_if.slave operand/result handshake
//  Revision    : 1.0 - initial release
// ============================================================================
module vector_normalize_iter
  import vector_norm_pkg::*;
#(
  parameter int WIDTH = C_FIXED_W,
  parameter int FRAC  = C_FIXED_FRACTION_W,
  parameter int DIM   = 3
) (
  input  wire                    clk,
  input  wire                    rst,
  vector_normalize_iter_if.slave bus
);

  localparam int QW  = q_width(WIDTH, DIM);
  localparam int TW  = t_width(WIDTH);
  localparam int PW  = prod_width(WIDTH, DIM);
  localparam int BW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PRW = 2 * WIDTH + 1;

  localparam logic [2:0] c_ST_IDLE   = IDLE;
  localparam logic [2:0] c_ST_SUMSQ  = SUMSQ;
  localparam logic [2:0] c_ST_SEARCH = SEARCH;
  localparam logic [2:0] c_ST_SCALE  = SCALE;
  localparam logic [2:0] c_ST_DONE   = DONE;

  localparam logic signed [PRW-1:0] c_SAT_MAX = {{(PRW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PRW-1:0] c_SAT_MIN = {{(PRW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic [2:0]           r_state;
  logic [DIM*WIDTH-1:0] r_vec;
  logic [WIDTH-1:0]     r_target;
  logic [QW-1:0]        r_q;
  logic [TW-1:0]        r_t;
  logic [WIDTH-1:0]     r_s;
  logic [BW-1:0]        r_b;
  logic [DIM*WIDTH-1:0] r_out_vec;
  logic [WIDTH-1:0]     r_out_scale;
  logic                 r_out_zero;
  logic                 r_out_clamped;

  logic                 w_in_ready;
  logic                 w_in_fire;
  logic [QW-1:0]        w_q;
  logic [TW-1:0]        w_t;
  logic [WIDTH-1:0]     w_trial;
  logic [TW-1:0]        w_trial_sq;
  logic [PW-1:0]        w_lhs;
  logic [PW-1:0]        w_rhs;
  logic                 w_trial_ok;
  logic [DIM*WIDTH-1:0] w_scaled;

  // Handshake: a result being taken frees the block for a new operand in the
  // same cycle.
  assign w_in_ready = (r_state == c_ST_IDLE) | ((r_state == c_ST_DONE) & bus.out_ready);
  assign w_in_fire  = bus.in_valid & w_in_ready;

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = (r_state == c_ST_DONE);
  assign bus.out_vec     = r_out_vec;
  assign bus.out_scale   = r_out_scale;
  assign bus.out_zero    = r_out_zero;
  assign bus.out_clamped = r_out_clamped;

  vector_sum_squares #(
    .WIDTH (WIDTH),
    .DIM   (DIM)
  ) u_sumsq (
    .i_vec   (r_vec),
    .o_sumsq (w_q)
  );

  assign w_t = TW'(r_target) * TW'(r_target);

  // Search step: accept the trial bit when trial^2 * Q <= T * 2^(2*FRAC).
  // Both sides are exact, so s ends as the floor of target/|v| in FRAC format.
  assign w_trial    = r_s | (WIDTH'(1) << r_b);
  assign w_trial_sq = TW'(w_trial) * TW'(w_trial);
  assign w_lhs      = PW'(w_trial_sq) * PW'(r_q);
  assign w_rhs      = PW'(r_t) << (2 * FRAC);
  assign w_trial_ok = (w_lhs <= w_rhs);

  // Scaling: signed component times unsigned scale, floor shift, saturate.
  for (genvar i = 0; i < DIM; i++) begin : g_scale
    logic        [WIDTH-1:0] w_c;
    logic signed [PRW-1:0]   w_c_ext;
    logic signed [PRW-1:0]   w_s_ext;
    logic signed [PRW-1:0]   w_prod;
    logic signed [PRW-1:0]   w_shr;
    assign w_c     = r_vec[i*WIDTH +: WIDTH];
    assign w_c_ext = {{(PRW-WIDTH){w_c[WIDTH-1]}}, w_c};
    assign w_s_ext = {{(PRW-WIDTH){1'b0}}, r_s};
    assign w_prod  = w_c_ext * w_s_ext;
    assign w_shr   = w_prod >>> FRAC;
    assign w_scaled[i*WIDTH +: WIDTH] =
        (w_shr > c_SAT_MAX) ? {1'b0, {(WIDTH-1){1'b1}}} :
        (w_shr < c_SAT_MIN) ? {1'b1, {(WIDTH-1){1'b0}}} :
                              w_shr[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= c_ST_IDLE;
      r_vec         <= '0;
      r_target      <= '0;
      r_q           <= '0;
      r_t           <= '0;
      r_s           <= '0;
      r_b           <= '0;
      r_out_vec     <= '0;
      r_out_scale   <= '0;
      r_out_zero    <= 1'b0;
      r_out_clamped <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_in_fire) begin
            r_vec    <= bus.in_vec;
            r_target <= bus.in_target;
            r_state  <= c_ST_SUMSQ;
          end
        end
        c_ST_SUMSQ: begin
          r_q     <= w_q;
          r_t     <= w_t;
          r_s     <= '0;
          r_b     <= BW'(WIDTH - 1);
          r_state <= c_ST_SEARCH;
        end
        c_ST_SEARCH: begin
          if (w_trial_ok) begin
            r_s <= w_trial;
          end
          if (r_b == '0) begin
            r_state <= c_ST_SCALE;
          end else begin
            r_b <= r_b - BW'(1);
          end
        end
        c_ST_SCALE: begin
          // A zero vector lets every trial pass; its result is forced here.
          if (r_q == '0) begin
            r_out_vec     <= '0;
            r_out_scale   <= '0;
            r_out_zero    <= 1'b1;
            r_out_clamped <= 1'b0;
          end else begin
            r_out_vec     <= w_scaled;
            r_out_scale   <= r_s;
            r_out_zero    <= 1'b0;
            r_out_clamped <= &r_s;
          end
          r_state <= c_ST_DONE;
        end
        c_ST_DONE: begin
          if (bus.out_ready) begin
            if (w_in_fire) begin
              r_vec    <= bus.in_vec;
              r_target <= bus.in_target;
              r_state  <= c_ST_SUMSQ;
            end else begin
              r_state  <= c_ST_IDLE;
            end
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
